// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and hex-to-segment decode for the 7-segment scan driver
package seven_seg_pkg;

  localparam int SEG_W = 7;

  // Entry n holds {a,b,c,d,e,f,g} for hex digit n; index 15 is listed first.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// rtl/seven_seg_scan_driver_if.sv - datapath-side value/load bus; blink lane present with SEVEN_SEG_BLINK_EN
interface seven_seg_scan_driver_if #(
  parameter int N_DIGITS = 4
);

  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  load;
  logic                  lz_blank;

`ifdef SEVEN_SEG_BLINK_EN
  logic [N_DIGITS-1:0]   blink;

  modport master (output value, dp_in, load, lz_blank, blink);
  modport slave  (input  value, dp_in, load, lz_blank, blink);
`else
  modport master (output value, dp_in, load, lz_blank);
  modport slave  (input  value, dp_in, load, lz_blank);
`endif

endinterface

// File: rtl/seven_seg_prescaler.sv
// rtl/seven_seg_prescaler.sv - slot-rate prescaler producing the slot tick and the guard window flag
module seven_seg_prescaler #(
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic in_guard
);

  localparam int CNT_W = $clog2(PRESCALE);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A zero-length guard would make the compare constant, so it is elaborated away.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt < CNT_W'(GUARD));
    end
  endgenerate

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - double-buffered multiplexed 7-segment scan driver; optional blink via SEVEN_SEG_BLINK_EN
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int PRESCALE       = 50000,
  parameter int GUARD          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
`ifdef SEVEN_SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seven_seg_scan_driver_if.slave bus,
  output logic [SEG_W-1:0]     seg,
  output logic                 dp,
  output logic [N_DIGITS-1:0]  an,
  output logic                 frame_done
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [SEG_W-1:0]    SEG_INV  = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] AN_INV   = {N_DIGITS{AN_ACTIVE_LOW}};

  logic                      tick;
  logic                      in_guard;
  logic                      frame_end;
  logic [IDX_W-1:0]          idx;

  logic [N_DIGITS-1:0][3:0]  pend_val;
  logic [N_DIGITS-1:0]       pend_dp;
  logic                      pend_valid;
  logic [N_DIGITS-1:0][3:0]  disp_val;
  logic [N_DIGITS-1:0]       disp_dp;

  logic [N_DIGITS-1:0]       lz_mask;
  logic                      zero_above;
  logic                      blink_off;

  logic [SEG_W-1:0]          seg_raw;
  logic                      dp_raw;
  logic [N_DIGITS-1:0]       an_raw;

  seven_seg_prescaler #(
    .PRESCALE (PRESCALE),
    .GUARD    (GUARD)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .in_guard (in_guard)
  );

  assign frame_end = tick && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // The display copy only changes between frames, so a frame never mixes two values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
    end else begin
      if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_in;
      end
      if (frame_end) begin
        pend_valid <= 1'b0;
        if (bus.load) begin
          disp_val <= bus.value;
          disp_dp  <= bus.dp_in;
        end else if (pend_valid) begin
          disp_val <= pend_val;
          disp_dp  <= pend_dp;
        end
      end else if (bus.load) begin
        pend_valid <= 1'b1;
      end
    end
  end

`ifdef SEVEN_SEG_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [N_DIGITS-1:0] pend_blink;
  logic [N_DIGITS-1:0] disp_blink;
  logic [FC_W-1:0]     frame_cnt;
  logic                blink_phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_blink <= '0;
      disp_blink <= '0;
    end else begin
      if (bus.load) begin
        pend_blink <= bus.blink;
      end
      if (frame_end) begin
        if (bus.load) begin
          disp_blink <= bus.blink;
        end else if (pend_valid) begin
          disp_blink <= pend_blink;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink_off = blink_phase && disp_blink[idx];
`else
  assign blink_off = 1'b0;
`endif

  // lz_mask[i] is set when digit i and every digit above it hold zero; digit 0 stays lit.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (disp_val[i] == 4'h0);
      lz_mask[i] = zero_above;
    end
  end

  always_comb begin
    seg_raw = '0;
    dp_raw  = 1'b0;
    an_raw  = '0;
    if (!in_guard) begin
      an_raw = N_DIGITS'(1) << idx;
      if (!blink_off) begin
        dp_raw = disp_dp[idx];
        if (!(bus.lz_blank && lz_mask[idx])) begin
          seg_raw = hex_to_seg(disp_val[idx]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg        <= SEG_INV;
      dp         <= SEG_ACTIVE_LOW;
      an         <= AN_INV;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_raw ^ SEG_INV;
      dp         <= dp_raw ^ SEG_ACTIVE_LOW;
      an         <= an_raw ^ AN_INV;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - table-driven frame-by-frame check of the scan driver
module tb_seven_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] cap_seg [4];
  logic       cap_dp  [4];

  typedef struct {
    int          la1;
    logic [15:0] v1;
    logic [3:0]  d1;
    int          la2;
    logic [15:0] v2;
    logic [3:0]  d2;
    logic        lz;
    logic [3:0][6:0] exp_seg;
    logic [3:0]  exp_dp;
  } vec_t;

  vec_t vecs [10];

  seven_seg_scan_driver_if #(.N_DIGITS(4)) bus ();

  seven_seg_scan_driver #(
    .N_DIGITS       (4),
    .PRESCALE       (4),
    .GUARD          (1),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Runs exactly one 16-cycle frame starting right after a frame_done sample
  // (or right after reset release); sample s sees slot s/4, cycle s%4.
  task automatic capture_frame(input int la1, input logic [15:0] v1, input logic [3:0] d1,
                               input int la2, input logic [15:0] v2, input logic [3:0] d2,
                               input logic lz);
    logic [3:0] one_hot;
    for (int s = 0; s < 16; s++) begin
      bus.lz_blank = lz;
      bus.load     = (s == la1) || (s == la2);
      bus.value    = (s == la2) ? v2 : v1;
      bus.dp_in    = (s == la2) ? d2 : d1;
      @(negedge clk);
      if (s % 4 == 0) begin
        check($sformatf("guard_an_s%0d", s), 32'(an), 32'h0);
        check($sformatf("guard_segdp_s%0d", s), 32'({dp, seg}), 32'h0);
      end else begin
        one_hot = 4'b0001 << (s / 4);
        check($sformatf("an_s%0d", s), 32'(an), 32'(one_hot));
      end
      if (s % 4 == 3) begin
        cap_seg[s / 4] = seg;
        cap_dp[s / 4]  = dp;
      end
      check($sformatf("frame_done_s%0d", s), 32'(frame_done), (s == 15) ? 32'h1 : 32'h0);
    end
    bus.load = 1'b0;
  endtask

  task automatic check_captured(input string tag, input logic [3:0][6:0] es, input logic [3:0] ed);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_seg%0d", tag, d), 32'(cap_seg[d]), 32'(es[d]));
      check($sformatf("%s_dp%0d", tag, d), 32'(cap_dp[d]), 32'(ed[d]));
    end
  endtask

  initial begin
    vecs[0] = '{la1:5,  v1:16'h12AF, d1:4'b0100, la2:-1, v2:16'h0,    d2:4'h0, lz:1'b0,
                exp_seg:{4{7'h7E}}, exp_dp:4'b0000};
    vecs[1] = '{la1:-1, v1:16'h0,    d1:4'h0,    la2:-1, v2:16'h0,    d2:4'h0, lz:1'b0,
                exp_seg:{7'h30, 7'h6D, 7'h77, 7'h47}, exp_dp:4'b0100};
    vecs[2] = '{la1:2,  v1:16'h0050, d1:4'h0,    la2:-1, v2:16'h0,    d2:4'h0, lz:1'b1,
                exp_seg:{7'h30, 7'h6D, 7'h77, 7'h47}, exp_dp:4'b0100};
    vecs[3] = '{la1:-1, v1:16'h0,    d1:4'h0,    la2:-1, v2:16'h0,    d2:4'h0, lz:1'b1,
                exp_seg:{7'h00, 7'h00, 7'h5B, 7'h7E}, exp_dp:4'b0000};
    vecs[4] = '{la1:0,  v1:16'h0000, d1:4'b1000, la2:-1, v2:16'h0,    d2:4'h0, lz:1'b1,
                exp_seg:{7'h00, 7'h00, 7'h5B, 7'h7E}, exp_dp:4'b0000};
    vecs[5] = '{la1:-1, v1:16'h0,    d1:4'h0,    la2:-1, v2:16'h0,    d2:4'h0, lz:1'b1,
                exp_seg:{7'h00, 7'h00, 7'h00, 7'h7E}, exp_dp:4'b1000};
    vecs[6] = '{la1:-1, v1:16'h0,    d1:4'h0,    la2:-1, v2:16'h0,    d2:4'h0, lz:1'b0,
                exp_seg:{4{7'h7E}}, exp_dp:4'b1000};
    vecs[7] = '{la1:3,  v1:16'h1111, d1:4'h0,    la2:15, v2:16'h8888, d2:4'h0, lz:1'b0,
                exp_seg:{4{7'h7E}}, exp_dp:4'b1000};
    vecs[8] = '{la1:-1, v1:16'h0,    d1:4'h0,    la2:-1, v2:16'h0,    d2:4'h0, lz:1'b0,
                exp_seg:{4{7'h7F}}, exp_dp:4'b0000};
    vecs[9] = '{la1:-1, v1:16'h0,    d1:4'h0,    la2:-1, v2:16'h0,    d2:4'h0, lz:1'b0,
                exp_seg:{4{7'h7F}}, exp_dp:4'b0000};

    rst_n        = 1'b0;
    bus.value    = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.lz_blank = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
    bus.blink    = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset_an", 32'(an), 32'h0);
    check("reset_seg", 32'(seg), 32'h0);
    check("reset_dp", 32'(dp), 32'h0);
    check("reset_frame_done", 32'(frame_done), 32'h0);

    rst_n = 1'b1;
    capture_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 1'b0);
    check_captured("first_frame", {4{7'h7E}}, 4'b0000);

    for (int v = 0; v < 10; v++) begin
      capture_frame(vecs[v].la1, vecs[v].v1, vecs[v].d1,
                    vecs[v].la2, vecs[v].v2, vecs[v].d2, vecs[v].lz);
      check_captured($sformatf("vec%0d", v), vecs[v].exp_seg, vecs[v].exp_dp);
    end

    // Park data in the pending buffer, then reset while digit 2 is being scanned.
    for (int s = 0; s < 9; s++) begin
      bus.load  = (s == 3);
      bus.value = 16'h5555;
      bus.dp_in = 4'b1111;
      @(negedge clk);
    end
    bus.load = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check("midrst_an", 32'(an), 32'h0);
    check("midrst_seg", 32'(seg), 32'h0);
    check("midrst_dp", 32'(dp), 32'h0);
    check("midrst_frame_done", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    capture_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 1'b0);
    check_captured("after_rst0", {4{7'h7E}}, 4'b0000);
    capture_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 1'b0);
    check_captured("after_rst1", {4{7'h7E}}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
